// File: rtl/var_delay_pipe_pkg.sv
// -----------------------------------------------------------------------------
// var_delay_pkg
//   Shared types and defaults for the runtime-configurable delay line.
//   - delay_width(): width of a field that must hold 0..max_delay
//   - *_DEF localparams: default geometry used by the top and its interface
//   - delay_t / lane_vec_t: convenience types for the default geometry
//   - cfg_state_t: states of the delay-change controller
// -----------------------------------------------------------------------------
package var_delay_pkg;

    function automatic int unsigned delay_width(input int unsigned max_delay);
        return $clog2(max_delay + 1);
    endfunction

    localparam int unsigned WIDTH_DEF         = 32;
    localparam int unsigned LANES_DEF         = 2;
    localparam int unsigned MAX_DELAY_DEF     = 16;
    localparam int unsigned DEFAULT_DELAY_DEF = 3;
    localparam int unsigned DW_DEF            = delay_width(MAX_DELAY_DEF);

    typedef logic [DW_DEF-1:0]                  delay_t;
    typedef logic [LANES_DEF*WIDTH_DEF-1:0]     lane_vec_t;

    typedef enum logic [0:0] {
        CFG_IDLE    = 1'b0,
        CFG_PENDING = 1'b1
    } cfg_state_t;

endpackage

// File: rtl/var_delay_pipe_if.sv
// -----------------------------------------------------------------------------
// var_delay_pipe_if
//   Bundles the stream, control and configuration signals of var_delay_pipe.
//   master: upstream/controller side (drives en, flush, in_*, cfg_load/delay)
//   slave : the delay line (drives cfg_busy, cur_delay, occupancy, out_*)
//   in_data/out_data carry LANES lanes of WIDTH bits, lane0 in the LSBs.
// -----------------------------------------------------------------------------
interface var_delay_pipe_if
    import var_delay_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned LANES     = LANES_DEF,
    parameter int unsigned MAX_DELAY = MAX_DELAY_DEF
);
    localparam int unsigned DW = delay_width(MAX_DELAY);

    logic                   en;
    logic                   flush;
    logic                   in_valid;
    logic [LANES*WIDTH-1:0] in_data;
    logic                   cfg_load;
    logic [DW-1:0]          cfg_delay;
    logic                   cfg_busy;
    logic [DW-1:0]          cur_delay;
    logic [DW-1:0]          occupancy;
    logic                   out_valid;
    logic [LANES*WIDTH-1:0] out_data;

    modport master (
        output en, flush, in_valid, in_data, cfg_load, cfg_delay,
        input  cfg_busy, cur_delay, occupancy, out_valid, out_data
    );

    modport slave (
        input  en, flush, in_valid, in_data, cfg_load, cfg_delay,
        output cfg_busy, cur_delay, occupancy, out_valid, out_data
    );

endinterface

// File: rtl/var_delay_pipe_tap_mux.sv
// -----------------------------------------------------------------------------
// var_delay_tap_mux
//   Combinational tap select for a shift-register delay line.
//   delay_i == 1       -> tap the line input directly
//   delay_i == 2..N+1  -> tap stage[delay_i-2]
//   Any other value falls back to the line input.
//   Ports: delay_i, in_valid_i/in_data_i, stage_valid_i/stage_data_i[NSTAGES],
//          tap_valid_o/tap_data_o.
// -----------------------------------------------------------------------------
module var_delay_tap_mux #(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned NSTAGES = 15,
    parameter int unsigned DW      = 5
) (
    input  logic [DW-1:0]     delay_i,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [NSTAGES-1:0] stage_valid_i,
    input  logic [DATA_W-1:0] stage_data_i [NSTAGES],
    output logic              tap_valid_o,
    output logic [DATA_W-1:0] tap_data_o
);

    // NOTE: every output gets a value before any condition is tested, so no
    // path through this block leaves it unassigned and no latch is inferred.
    always_comb begin
        tap_valid_o = in_valid_i;
        tap_data_o  = in_data_i;
        for (int i = 0; i < int'(NSTAGES); i++) begin
            if (delay_i == DW'(i + 2)) begin
                tap_valid_o = stage_valid_i[i];
                tap_data_o  = stage_data_i[i];
            end
        end
    end

endmodule

// File: rtl/var_delay_pipe.sv
// -----------------------------------------------------------------------------
// var_delay_pipe
//   Multi-lane, stallable delay line whose latency (1..MAX_DELAY) is changed
//   at runtime. A requested change waits until no valid beat is in flight so
//   nothing is lost or duplicated. Output data is zero whenever out_valid=0.
//   Ports: clk, rst (async, active high), bus (var_delay_pipe_if.slave):
//     en, flush, in_valid, in_data, cfg_load, cfg_delay   (inputs)
//     cfg_busy, cur_delay, occupancy, out_valid, out_data (outputs)
// -----------------------------------------------------------------------------
module var_delay_pipe
    import var_delay_pkg::*;
#(
    parameter int unsigned WIDTH         = WIDTH_DEF,
    parameter int unsigned LANES         = LANES_DEF,
    parameter int unsigned MAX_DELAY     = MAX_DELAY_DEF,
    parameter int unsigned DEFAULT_DELAY = DEFAULT_DELAY_DEF
) (
    input logic             clk,
    input logic             rst,
    var_delay_pipe_if.slave bus
);

    localparam int unsigned DW      = delay_width(MAX_DELAY);
    localparam int unsigned DATA_W  = LANES * WIDTH;
    localparam int unsigned NSTAGES = MAX_DELAY - 1;

    // Stage storage s[0..MAX_DELAY-2] plus the output register.
    logic [NSTAGES-1:0] stage_valid_q, stage_valid_d;
    logic [DATA_W-1:0]  stage_data_q [NSTAGES];
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;

    // Occupancy and delay-change controller.
    logic [DW-1:0] occ_q, occ_d;
    cfg_state_t    cfg_state_q, cfg_state_d;
    logic [DW-1:0] pend_q, pend_d;
    logic [DW-1:0] cur_delay_q, cur_delay_d;
    logic [DW-1:0] cfg_clamped;
    logic          apply_cfg;

    logic              accept;
    logic              retire;
    logic              tap_valid;
    logic [DATA_W-1:0] tap_data;

    assign accept = bus.en && bus.in_valid;
    assign retire = bus.en && out_valid_q;

    var_delay_tap_mux #(
        .DATA_W  (DATA_W),
        .NSTAGES (NSTAGES),
        .DW      (DW)
    ) u_tap_mux (
        .delay_i       (cur_delay_q),
        .in_valid_i    (bus.in_valid),
        .in_data_i     (bus.in_data),
        .stage_valid_i (stage_valid_q),
        .stage_data_i  (stage_data_q),
        .tap_valid_o   (tap_valid),
        .tap_data_o    (tap_data)
    );

    // ---------------- stage valids and output register -----------------
    always_comb begin
        stage_valid_d = stage_valid_q;
        // Applying a new delay also purges stale beats sitting past the old
        // tap; they would otherwise surface under a longer delay.
        if (bus.flush || apply_cfg) begin
            stage_valid_d = '0;
        end else if (bus.en) begin
            stage_valid_d[0] = bus.in_valid;
            for (int i = 1; i < int'(NSTAGES); i++) begin
                stage_valid_d[i] = stage_valid_q[i-1];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (bus.flush) begin
            out_valid_d = 1'b0;
            out_data_d  = '0;
        end else if (bus.en) begin
            out_valid_d = tap_valid;
            out_data_d  = tap_valid ? tap_data : '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_valid_q <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            stage_valid_q <= stage_valid_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    // Stage data only shifts; flush leaves it stale since the valids mask it.
    // NOTE: this is a flop array, not RAM, so it can take the async reset;
    // clearing it keeps post-reset state fully deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NSTAGES); i++) begin
                stage_data_q[i] <= '0;
            end
        end else if (bus.en) begin
            stage_data_q[0] <= bus.in_data;
            for (int i = 1; i < int'(NSTAGES); i++) begin
                stage_data_q[i] <= stage_data_q[i-1];
            end
        end
    end

    // ---------------- occupancy ----------------------------------------
    always_comb begin
        occ_d = occ_q;
        if (bus.flush) begin
            occ_d = '0;
        end else if (accept && !retire) begin
            occ_d = occ_q + DW'(1);
        end else if (!accept && retire) begin
            occ_d = occ_q - DW'(1);
        end
    end

    // ---------------- delay-change controller --------------------------
    always_comb begin
        cfg_clamped = bus.cfg_delay;
        if (bus.cfg_delay == '0) begin
            cfg_clamped = DW'(1);
        end else if (bus.cfg_delay > DW'(MAX_DELAY)) begin
            cfg_clamped = DW'(MAX_DELAY);
        end
    end

    always_comb begin
        cfg_state_d = cfg_state_q;
        pend_d      = pend_q;
        cur_delay_d = cur_delay_q;
        apply_cfg   = 1'b0;
        if (bus.cfg_load) begin
            // Last request wins; a load also holds off the apply for a cycle.
            pend_d      = cfg_clamped;
            cfg_state_d = CFG_PENDING;
        end else begin
            case (cfg_state_q)
                CFG_IDLE: cfg_state_d = CFG_IDLE;
                CFG_PENDING: begin
                    // Only switch with nothing in flight and nothing arriving;
                    // a flush edge is left to settle before the switch.
                    if (occ_q == '0 && !accept && !bus.flush) begin
                        apply_cfg   = 1'b1;
                        cur_delay_d = pend_q;
                        cfg_state_d = CFG_IDLE;
                    end
                end
                default: cfg_state_d = CFG_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ_q       <= '0;
            cfg_state_q <= CFG_IDLE;
            pend_q      <= '0;
            cur_delay_q <= DW'(DEFAULT_DELAY);
        end else begin
            occ_q       <= occ_d;
            cfg_state_q <= cfg_state_d;
            pend_q      <= pend_d;
            cur_delay_q <= cur_delay_d;
        end
    end

    assign bus.cfg_busy  = (cfg_state_q == CFG_PENDING);
    assign bus.cur_delay = cur_delay_q;
    assign bus.occupancy = occ_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_var_delay_pipe.sv
// -----------------------------------------------------------------------------
// tb_var_delay_pipe
//   Directed scenarios with literal expectations, then randomized traffic.
//   A queue-based reference model tracks every accepted beat with the number
//   of enabled edges it still has to wait, and a compare process checks all
//   DUT outputs against it on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_var_delay_pipe;
    import var_delay_pkg::*;

    localparam int unsigned W    = WIDTH_DEF;
    localparam int unsigned L    = LANES_DEF;
    localparam int unsigned MAXD = MAX_DELAY_DEF;
    localparam int unsigned DEFD = DEFAULT_DELAY_DEF;
    localparam int unsigned DWT  = delay_width(MAXD);

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    var_delay_pipe_if #(.WIDTH(W), .LANES(L), .MAX_DELAY(MAXD)) bus ();

    var_delay_pipe #(
        .WIDTH(W), .LANES(L), .MAX_DELAY(MAXD), .DEFAULT_DELAY(DEFD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model -----------------------------------
    typedef struct {
        lane_vec_t data;
        int        left;   // enabled edges still to wait before reaching out
    } beat_t;

    beat_t     m_q[$];
    bit        m_ov;
    lane_vec_t m_od;
    int        m_cur;
    bit        m_busy;
    int        m_pend;

    task automatic model_reset();
        m_q.delete();
        m_ov   = 1'b0;
        m_od   = '0;
        m_cur  = DEFD;
        m_busy = 1'b0;
        m_pend = 0;
    endtask

    task automatic model_step();
        int    occ_pre;
        bit    apply;
        bit    nov;
        lane_vec_t nod;
        int    req;
        beat_t nb;
        beat_t gone;
        occ_pre = m_q.size() + (m_ov ? 1 : 0);
        apply = m_busy && occ_pre == 0 && !(bus.en && bus.in_valid)
                && !bus.cfg_load && !bus.flush;
        if (bus.flush) begin
            m_q.delete();
            m_ov = 1'b0;
            m_od = '0;
        end else if (bus.en) begin
            nov = 1'b0;
            nod = '0;
            foreach (m_q[i]) m_q[i].left = m_q[i].left - 1;
            if (m_q.size() > 0 && m_q[0].left == 0) begin
                nov  = 1'b1;
                nod  = m_q[0].data;
                gone = m_q.pop_front();
            end
            if (bus.in_valid) begin
                if (m_cur == 1) begin
                    nov = 1'b1;
                    nod = bus.in_data;
                end else begin
                    nb.data = bus.in_data;
                    nb.left = m_cur - 1;
                    m_q.push_back(nb);
                end
            end
            m_ov = nov;
            m_od = nod;
        end
        if (bus.cfg_load) begin
            req = int'(bus.cfg_delay);
            if (req == 0) req = 1;
            if (req > int'(MAXD)) req = int'(MAXD);
            m_pend = req;
            m_busy = 1'b1;
        end else if (apply) begin
            m_cur  = m_pend;
            m_busy = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step();
        end
    end

    // ---------------- compare process -----------------------------------
    initial begin
        forever begin
            @(negedge clk);
            check("m.out_valid", 64'(bus.out_valid), 64'(m_ov));
            check("m.out_data",  64'(bus.out_data),  64'(m_od));
            check("m.occupancy", 64'(bus.occupancy), 64'(m_q.size() + (m_ov ? 1 : 0)));
            check("m.cur_delay", 64'(bus.cur_delay), 64'(m_cur));
            check("m.cfg_busy",  64'(bus.cfg_busy),  64'(m_busy));
        end
    end

    // ---------------- stimulus ------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.en        = 1'b1;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.cfg_load  = 1'b0;
        bus.cfg_delay = '0;
    endtask

    task automatic chk_out(input string name, input bit ov, input lane_vec_t od, input int occ);
        check({name, ".out_valid"}, 64'(bus.out_valid), 64'(ov));
        check({name, ".out_data"},  64'(bus.out_data),  64'(od));
        check({name, ".occupancy"}, 64'(bus.occupancy), 64'(occ));
    endtask

    task automatic chk_cfg(input string name, input bit busy, input int cur);
        check({name, ".cfg_busy"},  64'(bus.cfg_busy),  64'(busy));
        check({name, ".cur_delay"}, 64'(bus.cur_delay), 64'(cur));
    endtask

    lane_vec_t beat_a;
    lane_vec_t beat_b;
    bit        quiet;

    initial begin
        rst = 1'b1;
        drive_idle();
        repeat (2) tick();
        chk_out("reset", 1'b0, '0, 0);
        chk_cfg("reset", 1'b0, 3);
        rst = 1'b0;

        // Single beat at D=3: visible after the third edge.
        beat_a = 64'h22222222_11111111;
        bus.in_valid = 1'b1; bus.in_data = beat_a;
        tick(); bus.in_valid = 1'b0; bus.in_data = '0;
        chk_out("d3.e1", 1'b0, '0, 1);
        tick(); chk_out("d3.e2", 1'b0, '0, 1);
        tick(); chk_out("d3.e3", 1'b1, beat_a, 1);
        tick(); chk_out("d3.e4", 1'b0, '0, 0);

        // Same beat with a two-cycle stall mid-flight, then a stall at output.
        bus.in_valid = 1'b1; bus.in_data = beat_a;
        tick(); bus.in_valid = 1'b0; bus.in_data = '0;
        tick();
        bus.en = 1'b0;
        tick(); chk_out("stall.e3", 1'b0, '0, 1);
        tick(); chk_out("stall.e4", 1'b0, '0, 1);
        bus.en = 1'b1;
        tick(); chk_out("stall.e5", 1'b1, beat_a, 1);
        bus.en = 1'b0;
        tick(); chk_out("stall.hold", 1'b1, beat_a, 1);
        bus.en = 1'b1;
        tick(); chk_out("stall.drain", 1'b0, '0, 0);

        // Change to D=4 while idle, then a gapless stream.
        bus.cfg_load = 1'b1; bus.cfg_delay = delay_t'(4);
        tick(); bus.cfg_load = 1'b0;
        chk_cfg("d4.load", 1'b1, 3);
        tick(); chk_cfg("d4.apply", 1'b0, 4);
        for (int i = 1; i <= 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = {32'(i + 100), 32'(i)};
            tick();
            if (i >= 4) chk_out("d4.stream", 1'b1, {32'(i - 3 + 100), 32'(i - 3)}, 4);
            else        chk_out("d4.stream", 1'b0, '0, i);
        end
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (4) tick();
        chk_out("d4.empty", 1'b0, '0, 0);

        // Request 20 (clamps to 16) with three beats in flight.
        for (int i = 1; i <= 3; i++) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = 64'(32'hA0 + i);
            bus.cfg_load  = (i == 3);
            bus.cfg_delay = delay_t'(20);
            tick();
        end
        bus.in_valid = 1'b0; bus.cfg_load = 1'b0;
        chk_cfg("clamp.busy", 1'b1, 4);
        check("clamp.occ", 64'(bus.occupancy), 64'd3);
        for (int j = 1; j <= 3; j++) begin
            tick();
            check("clamp.exit.valid", 64'(bus.out_valid), 64'd1);
            check("clamp.exit.data", 64'(bus.out_data), 64'(32'hA0 + j));
            chk_cfg("clamp.exit", 1'b1, 4);
        end
        tick(); chk_out("clamp.drained", 1'b0, '0, 0);
        chk_cfg("clamp.still_busy", 1'b1, 4);
        tick(); chk_cfg("clamp.apply", 1'b0, 16);
        beat_b = 64'hDEADBEEF_CAFEF00D;
        bus.in_valid = 1'b1; bus.in_data = beat_b;
        tick(); bus.in_valid = 1'b0; bus.in_data = '0;
        for (int t = 1; t <= 15; t++) begin
            tick();
            check("d16.valid", 64'(bus.out_valid), 64'(t == 15));
        end
        check("d16.data", 64'(bus.out_data), 64'(beat_b));
        tick();

        // Zero request clamps to 1; then two loads back to back.
        bus.cfg_load = 1'b1; bus.cfg_delay = '0;
        tick(); bus.cfg_load = 1'b0;
        chk_cfg("d1.load", 1'b1, 16);
        tick(); chk_cfg("d1.apply", 1'b0, 1);
        bus.in_valid = 1'b1; bus.in_data = beat_a;
        tick(); bus.in_valid = 1'b0;
        chk_out("d1.next_edge", 1'b1, beat_a, 1);
        tick(); chk_out("d1.drain", 1'b0, '0, 0);
        bus.cfg_load = 1'b1; bus.cfg_delay = delay_t'(5);
        tick(); chk_cfg("lastwins.first", 1'b1, 1);
        bus.cfg_delay = delay_t'(7);
        tick(); chk_cfg("lastwins.second", 1'b1, 1);
        bus.cfg_load = 1'b0;
        tick(); chk_cfg("lastwins.apply", 1'b0, 7);

        // Flush with two beats in flight and a beat on the input.
        bus.in_valid = 1'b1; bus.in_data = beat_a;
        repeat (2) tick();
        bus.flush = 1'b1; bus.in_data = beat_b;
        tick(); bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk_out("flush.edge", 1'b0, '0, 0);
        for (int t = 0; t < 10; t++) begin
            tick();
            check("flush.nothing", 64'(bus.out_valid), 64'd0);
        end

        // Flush while a change is pending: applies on the edge after.
        bus.cfg_load = 1'b1; bus.cfg_delay = delay_t'(2);
        tick(); bus.cfg_load = 1'b0; bus.flush = 1'b1;
        tick(); bus.flush = 1'b0;
        chk_cfg("flushbusy.hold", 1'b1, 7);
        tick(); chk_cfg("flushbusy.apply", 1'b0, 2);

        // Async reset mid-stream.
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = {$urandom, $urandom};
            tick();
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, '0, 0);
        chk_cfg("async_rst", 1'b0, 3);
        bus.in_valid = 1'b0;
        tick(); rst = 1'b0;

        // Randomized traffic with quiet windows so pending changes complete.
        for (int c = 0; c < 4000; c++) begin
            quiet         = ((c / 150) % 3) == 2;
            bus.en        = ($urandom_range(0, 99) < 85);
            bus.in_valid  = quiet ? 1'b0 : ($urandom_range(0, 99) < 60);
            bus.in_data   = {$urandom, $urandom};
            bus.flush     = ($urandom_range(0, 99) < 3);
            bus.cfg_load  = ($urandom_range(0, 99) < 4);
            bus.cfg_delay = delay_t'($urandom_range(0, (1 << DWT) - 1));
            rst           = ($urandom_range(0, 799) == 0);
            tick();
        end
        rst = 1'b0;
        drive_idle();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
